timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  Memory-mapped timer peripheral on the CPU data bus. It sequences a reloadable 32-bit up-counter (TL/TH) and a
//  free-running system tick counter. It raises an interrupt to the pipeline's exception logic on counter overflow.
//  It decodes MEM-stage load/store accesses to its register window and returns read data in the same cycle.
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  byte address of register window (4 words, word-aligned)
//  PRESCALE   1              clk cycles per TL increment; legal range 1..65535
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  mem_read   in   1   bus read strobe (MEM stage)
//  mem_write  in   1   bus write strobe (MEM stage)
//  addr       in   32  byte address
//  wdata      in   32  write data
//  rdata      out  32  read data (combinational)
//  irq        out  1   interrupt request, level
// BEHAVIOUR
//  Register map, offsets from BASE_ADDR:
//   +0x0 TH: reload value, R/W.
//   +0x4 TL: count value, R/W.
//   +0x8 TCON, R/W:
//     [0] EN: timer enable.
//     [1] IE: interrupt enable.
//     [2] ST: status, write-1-to-clear.
//     [3] OS: one-shot mode.
//     [31:4] read as 0.
//   +0xC SYSTICK: read-only; writes are ignored.
//  Hit when addr[31:4]==BASE_ADDR[31:4]. addr[1:0] ignored.
//  Reset:
//   - TH=0, TL=0, TCON=0, SYSTICK=0, prescale counter=0, FSM=IDLE.
//   - irq=0.
//  SYSTICK: +1 every clk, wraps 32'hFFFF_FFFF -> 0, independent of EN.
//  Prescaler: counts 0..PRESCALE-1 while FSM=RUN, else held at 0. tick=1 on the cycle it equals PRESCALE-1.
//  FSM states IDLE, RUN, DONE:
//   - IDLE -> RUN when EN=1 (effective next cycle after the write).
//   - RUN on tick:
//     - TL!=32'hFFFF_FFFF: TL<=TL+1.
//     - TL==32'hFFFF_FFFF (overflow): TL<=TH, ST<=1.
//       - If OS=1: EN<=0, FSM->DONE.
//   - RUN -> IDLE when EN=0 (written by software). TL holds its value.
//   - DONE -> IDLE next cycle unconditionally.
//  irq = IE & ST (combinational from registers). Stays high until ST cleared or IE cleared.
//  Writes (mem_write & hit):
//   - TH/TL: take wdata at clk edge.
//   - TL write on the same cycle as a tick: write wins, no increment.
//   - TCON write: EN/IE/OS <= wdata[0]/[1]/[3]. ST <= ST & ~wdata[2].
//   - Overflow on the same cycle as an ST clear: set wins, ST=1.
//   - Overflow on the same cycle as an EN=0 write: reload and ST set still occur, then IDLE.
//  Reads: rdata = selected register when mem_read & hit, else 32'h0. No side effects on read.
//  mem_read & mem_write together: write performed, rdata returns pre-write value.
//  Reset asserted mid-count: all state cleared immediately. irq drops asynchronously.
// TESTING
//  1. reset, PRESCALE=1, TH=FFFF_FFFD, TL=FFFF_FFFD, TCON=3 -> TL=FFFF_FFFE,FFFF_FFFF,FFFF_FFFD over 3 ticks;
//     ST=1, irq=1 on the cycle after wrap.
//  2. With irq=1, write TCON=32'h7 -> ST=0, irq=0 next cycle, counting continues; TCON=32'h3 write leaves ST=1.
//  3. OS=1 (TCON=B), TL=FFFF_FFFF, TH=5 -> one tick: TL=5, ST=1, EN=0, TL frozen at 5 thereafter.
//  4. PRESCALE=4, TL=0, EN=1 -> TL reads 1 after 4 counting cycles, 2 after 8.
//  5. Overflow coincident with TCON write clearing ST -> ST=1, irq=1. TL write coincident with tick -> TL=wdata.
//  6. Read SYSTICK twice 10 cycles apart -> difference 10; read unmapped BASE+0x10 -> 0; assert reset mid-count
//     -> all reads 0, irq=0.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: memory-mapped reloadable 32-bit up-counter with prescaler, one-shot mode,
// overflow interrupt and a free-running SYSTICK counter.
`default_nettype none

module timer_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

   state_t      state_q, state_d;
   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [31:0] systick_q, systick_d;
   logic [15:0] presc_q, presc_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        st_q, st_d;
   logic        os_q, os_d;

   logic        hit;
   logic        wr;
   logic [1:0]  sel;
   logic        counting;
   logic        tick;
   logic        ovf;
   logic        unused_addr_bits;

   assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
   assign wr               = mem_write & hit;
   assign sel              = addr[3:2];
   assign counting         = (state_q == S_RUN) && en_q;
   assign tick             = counting && (presc_q == PS_MAX);
   assign ovf              = tick && (tl_q == 32'hFFFF_FFFF);
   assign unused_addr_bits = ^addr[1:0];

   always_comb begin
      state_d   = state_q;
      th_d      = th_q;
      tl_d      = tl_q;
      en_d      = en_q;
      ie_d      = ie_q;
      st_d      = st_q;
      os_d      = os_q;
      systick_d = systick_q + 32'd1;
      presc_d   = 16'd0;

      if (counting) begin
         presc_d = tick ? 16'd0 : presc_q + 16'd1;
      end

      if (tick) begin
         tl_d = ovf ? th_q : tl_q + 32'd1;
      end

      // Software writes override the increment; overflow status still wins over W1C below.
      if (wr) begin
         case (sel)
            2'd0: th_d = wdata;
            2'd1: tl_d = wdata;
            2'd2: begin
               en_d = wdata[0];
               ie_d = wdata[1];
               os_d = wdata[3];
               st_d = st_q & ~wdata[2];
            end
            default: ;
         endcase
      end

      if (ovf) begin
         st_d = 1'b1;
         if (os_q) begin
            en_d = 1'b0;
         end
      end

      case (state_q)
         S_IDLE:  if (en_q) state_d = S_RUN;
         S_RUN: begin
            if (ovf && os_q) begin
               state_d = S_DONE;
            end else if (!en_q) begin
               state_d = S_IDLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         th_q      <= 32'd0;
         tl_q      <= 32'd0;
         systick_q <= 32'd0;
         presc_q   <= 16'd0;
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         st_q      <= 1'b0;
         os_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         th_q      <= th_d;
         tl_q      <= tl_d;
         systick_q <= systick_d;
         presc_q   <= presc_d;
         en_q      <= en_d;
         ie_q      <= ie_d;
         st_q      <= st_d;
         os_q      <= os_d;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (mem_read && hit) begin
         case (sel)
            2'd0: rdata = th_q;
            2'd1: rdata = tl_q;
            2'd2: rdata = {28'd0, os_q, st_q, ie_q, en_q};
            2'd3: rdata = systick_q;
            default: rdata = 32'd0;
         endcase
      end
   end

   assign irq = ie_q & st_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed-vector bench for timer_ctrl (PRESCALE=1 and PRESCALE=4 instances).
`default_nettype none

module tb_timer_ctrl;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] A_TH = BASE + 32'h0;
   localparam logic [31:0] A_TL = BASE + 32'h4;
   localparam logic [31:0] A_TC = BASE + 32'h8;
   localparam logic [31:0] A_SY = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata4;
   logic        irq1, irq4;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] v1, v4, s0, s1;

   timer_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata1), .irq(irq1)
   );

   timer_ctrl #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata4), .irq(irq4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_write = 1'b1;
      addr      = a;
      wdata     = d;
      @(posedge clk);
      #1;
      mem_write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r1, output logic [31:0] r4);
      mem_read = 1'b1;
      addr     = a;
      #1;
      r1       = rdata1;
      r4       = rdata4;
      mem_read = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = 32'd0;
      wdata     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      rd(A_TH, v1, v4); chk("rst_th", v1, 32'h0);
      rd(A_TL, v1, v4); chk("rst_tl", v1, 32'h0);
      rd(A_TC, v1, v4); chk("rst_tcon", v1, 32'h0);
      chk("rst_irq", {31'd0, irq1}, 32'h0);

      // 1: count through wrap with reload
      wr(A_TH, 32'hFFFF_FFFD);
      wr(A_TL, 32'hFFFF_FFFD);
      wr(A_TC, 32'h3);
      step(1); rd(A_TL, v1, v4); chk("t1_tl0", v1, 32'hFFFF_FFFD);
      step(1); rd(A_TL, v1, v4); chk("t1_tl1", v1, 32'hFFFF_FFFE);
      step(1); rd(A_TL, v1, v4); chk("t1_tl2", v1, 32'hFFFF_FFFF);
      chk("t1_irq_pre", {31'd0, irq1}, 32'h0);
      step(1); rd(A_TL, v1, v4); chk("t1_tl_wrap", v1, 32'hFFFF_FFFD);
      rd(A_TC, v1, v4); chk("t1_tcon", v1, 32'h7);
      chk("t1_irq", {31'd0, irq1}, 32'h1);

      // 2: W1C clears ST, counting continues; writing 0 to ST bit leaves it set
      wr(A_TC, 32'h7);
      chk("t2_irq_clr", {31'd0, irq1}, 32'h0);
      rd(A_TL, v1, v4); chk("t2_tl", v1, 32'hFFFF_FFFE);
      step(2);
      chk("t2_irq_again", {31'd0, irq1}, 32'h1);
      wr(A_TC, 32'h3);
      rd(A_TC, v1, v4); chk("t2_tcon_keep", v1, 32'h7);
      chk("t2_irq_keep", {31'd0, irq1}, 32'h1);

      // 5a: overflow coincident with ST clear -> set wins
      step(1);
      wr(A_TC, 32'h7);
      rd(A_TC, v1, v4); chk("t5_tcon", v1, 32'h7);
      chk("t5_irq", {31'd0, irq1}, 32'h1);
      rd(A_TL, v1, v4); chk("t5_tl_reload", v1, 32'hFFFF_FFFD);
      // 5b: TL write coincident with tick -> write wins
      wr(A_TL, 32'h0000_1234);
      rd(A_TL, v1, v4); chk("t5_tl_wr", v1, 32'h0000_1234);
      step(1); rd(A_TL, v1, v4); chk("t5_tl_inc", v1, 32'h0000_1235);

      // 3: one-shot
      wr(A_TC, 32'h4);
      step(1);
      wr(A_TH, 32'h5);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TC, 32'hB);
      step(1); rd(A_TL, v1, v4); chk("t3_tl_pre", v1, 32'hFFFF_FFFF);
      step(1); rd(A_TL, v1, v4); chk("t3_tl_reload", v1, 32'h5);
      rd(A_TC, v1, v4); chk("t3_tcon", v1, 32'hE);
      chk("t3_irq", {31'd0, irq1}, 32'h1);
      step(5); rd(A_TL, v1, v4); chk("t3_tl_frozen", v1, 32'h5);

      // 4: PRESCALE=4 instance
      wr(A_TC, 32'h4);
      step(2);
      wr(A_TL, 32'h0);
      wr(A_TC, 32'h1);
      step(1);
      step(3); rd(A_TL, v1, v4); chk("t4_tl_c3", v4, 32'h0);
      step(1); rd(A_TL, v1, v4); chk("t4_tl_c4", v4, 32'h1);
      step(4); rd(A_TL, v1, v4); chk("t4_tl_c8", v4, 32'h2);

      // 6: SYSTICK, unmapped read, read+write, async reset
      rd(A_SY, s0, v4);
      step(10);
      rd(A_SY, s1, v4);
      chk("t6_systick_diff", s1 - s0, 32'd10);
      rd(BASE + 32'h10, v1, v4); chk("t6_unmapped", v1, 32'h0);
      mem_read  = 1'b1;
      mem_write = 1'b1;
      addr      = A_TH;
      wdata     = 32'h0000_00AA;
      #1;
      chk("t6_rw_old", rdata1, 32'h5);
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      rd(A_TH, v1, v4); chk("t6_rw_new", v1, 32'h0000_00AA);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TC, 32'h3);
      rd(A_TL, v1, v4); chk("t6_tl_reload", v1, 32'h0000_00AA);
      chk("t6_irq_pre", {31'd0, irq1}, 32'h1);
      reset = 1'b1;
      #1;
      chk("t6_irq_rst", {31'd0, irq1}, 32'h0);
      rd(A_TL, v1, v4); chk("t6_tl_rst", v1, 32'h0);
      rd(A_TC, v1, v4); chk("t6_tcon_rst", v1, 32'h0);
      rd(A_SY, v1, v4); chk("t6_sys_rst", v1, 32'h0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
